// File: rtl/sort_stream_ctrl.sv
// sort_stream_ctrl
// ----------------
// Streaming front-end and sole master of the 8-entry, 8-bit selection-sort
// engine. A frame of eight bytes is taken from the input stream and written
// straight into the engine. The engine is then started, and the controller
// waits for it to finish while counting how long it stayed busy. The sorted
// bytes are then read back one at a time onto the output stream, with
// out_last marking the eighth byte.
//
// Build option:
//   SORT_DESCENDING_EN - when defined, the engine is read from the top address
//                        down, so the frame drains largest byte first.
//
// Ports:
//   clk, nrst         clock, asynchronous active-low reset
//   in_valid/in_ready input byte handshake, in_data carries the byte
//   out_valid/out_ready output byte handshake, out_data/out_last
//   eng_start         one-cycle engine start pulse
//   eng_wr, eng_addr, eng_datain   engine write port / address
//   eng_dataout       engine registered read data (1-cycle latency)
//   eng_ready         engine idle
//   busy              high whenever not accepting input bytes
//   sort_cycles       busy time of the engine for the last frame, saturating
//   frame_cnt         completed frames, wraps
`timescale 1ns/1ps

module sort_stream_ctrl #(
  parameter int FRAME_LEN = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        eng_start,
  output logic        eng_wr,
  output logic [2:0]  eng_addr,
  output logic [7:0]  eng_datain,
  input  logic [7:0]  eng_dataout,
  input  logic        eng_ready,
  output logic        busy,
  output logic [7:0]  sort_cycles,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    KICK    = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    READ    = 3'd4,
    OUT     = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [2:0]  r_k;
  logic [2:0]  w_kNext;
  logic [7:0]  r_sortCycles;
  logic [7:0]  w_sortNext;
  logic [15:0] r_frameCnt;
  logic [15:0] w_frameNext;
  logic        w_kLast;
  logic [2:0]  w_readAddr;

  assign w_kLast = (r_k == 3'(FRAME_LEN - 1));

  // The engine always sorts ascending; descending output is obtained by
  // walking its addresses from the top down while k still counts up, so
  // out_last keeps marking the eighth byte either way.
`ifdef SORT_DESCENDING_EN
  assign w_readAddr = 3'(FRAME_LEN - 1) - r_k;
`else
  assign w_readAddr = r_k;
`endif

  // State, byte index and the two statistics counters.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= LOAD;
      r_k          <= 3'd0;
      r_sortCycles <= 8'd0;
      r_frameCnt   <= 16'd0;
    end else begin
      r_state      <= w_stateNext;
      r_k          <= w_kNext;
      r_sortCycles <= w_sortNext;
      r_frameCnt   <= w_frameNext;
    end
  end

  // Next-state logic and all stream/engine outputs. Engine signals are
  // purely combinational so a write lands in the same cycle as the input
  // handshake that carries it.
  always_comb begin
    w_stateNext = r_state;
    w_kNext     = r_k;
    w_sortNext  = r_sortCycles;
    w_frameNext = r_frameCnt;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    eng_start   = 1'b0;
    eng_wr      = 1'b0;
    eng_addr    = r_k;
    eng_datain  = in_data;

    case (r_state)
      LOAD: begin
        in_ready = 1'b1;
        eng_wr   = in_valid;
        if (in_valid) begin
          if (w_kLast) begin
            w_kNext     = 3'd0;
            w_stateNext = KICK;
          end else begin
            w_kNext = r_k + 3'd1;
          end
        end
      end
      KICK: begin
        eng_start   = 1'b1;
        w_sortNext  = 8'd0;
        w_stateNext = WAIT_LO;
      end
      // The engine may take a cycle to drop ready after the start pulse;
      // only a low ready here proves the sort has actually begun.
      WAIT_LO: begin
        if (!eng_ready) begin
          w_sortNext  = 8'd1;
          w_stateNext = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (eng_ready) begin
          w_stateNext = READ;
        end else if (r_sortCycles != 8'hFF) begin
          w_sortNext = r_sortCycles + 8'd1;
        end
      end
      READ: begin
        eng_addr    = w_readAddr;
        w_stateNext = OUT;
      end
      // Address stays put so the engine keeps re-reading the same entry and
      // out_data is stable while the downstream stalls.
      OUT: begin
        eng_addr  = w_readAddr;
        out_valid = 1'b1;
        out_last  = w_kLast;
        if (out_ready) begin
          if (w_kLast) begin
            w_kNext     = 3'd0;
            w_frameNext = r_frameCnt + 16'd1;
            w_stateNext = LOAD;
          end else begin
            w_kNext     = r_k + 3'd1;
            w_stateNext = READ;
          end
        end
      end
      default: begin
        w_stateNext = LOAD;
        w_kNext     = 3'd0;
      end
    endcase
  end

  assign out_data    = eng_dataout;
  assign busy        = (r_state != LOAD);
  assign sort_cycles = r_sortCycles;
  assign frame_cnt   = r_frameCnt;

endmodule

// File: tb/tb_sort_stream_ctrl.sv
// tb_sort_stream_ctrl
// -------------------
// Bench for sort_stream_ctrl. A behavioural sort engine answers the
// controller; a reference model tracks frames at the stream level (bytes in,
// sorted bytes out, frame and busy-time counters) and is compared against
// the controller every cycle.
`timescale 1ns/1ps

module tb_sort_stream_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        eng_start;
  logic        eng_wr;
  logic [2:0]  eng_addr;
  logic [7:0]  eng_datain;
  logic [7:0]  eng_dataout;
  logic        eng_ready;
  logic        busy;
  logic [7:0]  sort_cycles;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  sort_stream_ctrl dut (
    .clk         (clk),
    .nrst        (nrst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .eng_start   (eng_start),
    .eng_wr      (eng_wr),
    .eng_addr    (eng_addr),
    .eng_datain  (eng_datain),
    .eng_dataout (eng_dataout),
    .eng_ready   (eng_ready),
    .busy        (busy),
    .sort_cycles (sort_cycles),
    .frame_cnt   (frame_cnt)
  );

  // Behavioural sort engine: ready drops for engLat cycles after a start,
  // then the memory holds its contents in ascending order.
  logic [63:0] engMem;
  logic [7:0]  engDout;
  logic        engReadyR;
  int          engCnt;
  int          engLat = 45;

  function automatic logic [63:0] sortVec(input logic [63:0] v);
    logic [7:0]  a [8];
    logic [7:0]  t;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) a[i] = v[i*8 +: 8];
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i];
    return r;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      engReadyR <= 1'b1;
      engCnt    <= 0;
      engDout   <= 8'd0;
    end else begin
      if (eng_wr) engMem[{eng_addr, 3'b000} +: 8] <= eng_datain;
      if (engReadyR && !eng_wr) engDout <= engMem[{eng_addr, 3'b000} +: 8];
      if (engReadyR && eng_start) begin
        engReadyR <= 1'b0;
        engCnt    <= engLat;
      end else if (!engReadyR) begin
        engCnt <= engCnt - 1;
        if (engCnt == 1) begin
          engReadyR <= 1'b1;
          engMem    <= sortVec(engMem);
        end
      end
    end
  end

  assign eng_ready   = engReadyR;
  assign eng_dataout = engDout;

  // Reference model state and scoreboard.
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  txq[$];
  logic [7:0]  curFrame[$];
  logic [7:0]  expOut[$];
  int          expFrames;
  bit          expLoad;
  bit          kickDue;
  int          outIdx;
  bit          prevStall;
  logic [7:0]  prevData;
  int          readyMode = 0;
  int          stallLeft = 0;

  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Sorted order of a completed frame by repeated minimum extraction.
  task automatic refPush();
    logic [7:0] pool[$];
    logic [7:0] ordered[$];
    int m;
    pool = curFrame;
    while (pool.size() > 0) begin
      m = 0;
      for (int j = 1; j < pool.size(); j++)
        if (pool[j] < pool[m]) m = j;
      ordered.push_back(pool[m]);
      pool.delete(m);
    end
`ifdef SORT_DESCENDING_EN
    for (int j = 7; j >= 0; j--) expOut.push_back(ordered[j]);
`else
    for (int j = 0; j < 8; j++) expOut.push_back(ordered[j]);
`endif
  endtask

  // Cycle monitor on the falling edge: compares, then advances the model
  // by whatever handshakes the coming rising edge will complete.
  initial begin
    forever begin
      @(negedge clk);
      if (nrst) begin
        checkOutput("in_ready", 16'(in_ready), 16'(expLoad));
        checkOutput("busy", 16'(busy), 16'(!expLoad));
        checkOutput("eng_wr", 16'(eng_wr), 16'(in_valid && expLoad));
        checkOutput("eng_start", 16'(eng_start), 16'(kickDue));
        checkOutput("frame_cnt", frame_cnt, 16'(expFrames));
        if (expLoad) checkOutput("out_valid_load", 16'(out_valid), 16'd0);
        if (prevStall) begin
          checkOutput("hold_valid", 16'(out_valid), 16'd1);
          checkOutput("hold_data", 16'(out_data), 16'(prevData));
        end
        kickDue = 1'b0;
        if (out_valid && out_ready) begin
          if (expOut.size() == 0) begin
            checkOutput("out_valid_early", 16'(out_valid), 16'd0);
          end else begin
            checkOutput("out_data", 16'(out_data), 16'(expOut[0]));
            checkOutput("out_last", 16'(out_last), 16'(outIdx == 7));
            checkOutput("sort_cycles", 16'(sort_cycles), 16'(engLat > 255 ? 255 : engLat));
            void'(expOut.pop_front());
            outIdx++;
            if (outIdx == 8) begin
              outIdx    = 0;
              expFrames = (expFrames + 1) % 65536;
              expLoad   = 1'b1;
            end
          end
        end
        prevStall = out_valid && !out_ready;
        prevData  = out_data;
        if (in_valid && in_ready && expLoad) begin
          curFrame.push_back(in_data);
          if (curFrame.size() == 8) begin
            refPush();
            curFrame.delete();
            expLoad = 1'b0;
            kickDue = 1'b1;
          end
        end
      end
    end
  end

  // Downstream: always ready, random back-pressure, or a 10-cycle stall on
  // the third byte of a frame.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        1:       out_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (out_valid && outIdx == 2 && stallLeft > 0) begin
            out_ready = 1'b0;
            stallLeft--;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic doReset();
    nrst     = 1'b0;
    in_valid = 1'b0;
    txq.delete();
    curFrame.delete();
    expOut.delete();
    expFrames = 0;
    expLoad   = 1'b1;
    kickDue   = 1'b0;
    outIdx    = 0;
    prevStall = 1'b0;
    #1;
    checkOutput("rst_in_ready", 16'(in_ready), 16'd1);
    checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
    checkOutput("rst_out_last", 16'(out_last), 16'd0);
    checkOutput("rst_eng_start", 16'(eng_start), 16'd0);
    checkOutput("rst_eng_wr", 16'(eng_wr), 16'd0);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_sort_cycles", 16'(sort_cycles), 16'd0);
    checkOutput("rst_frame_cnt", frame_cnt, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  // Drives txq onto the input stream. inMode 0: full rate, 1: valid every
  // other cycle, 2: random gaps. Returns once the queue is consumed
  // (stopAfterLoad) or once every frame has also drained.
  task automatic applyStimulus(input int inMode, input bit stopAfterLoad);
    int cyc;
    bit hs;
    bit timedOut;
    cyc      = 0;
    timedOut = 1'b1;
    @(posedge clk);
    #1;
    while (cyc < 5000) begin
      if (stopAfterLoad ? (txq.size() == 0)
          : (txq.size() == 0 && expOut.size() == 0 && curFrame.size() == 0 &&
             expLoad && outIdx == 0)) begin
        timedOut = 1'b0;
        break;
      end
      case (inMode)
        1:       in_valid = (txq.size() > 0) && (cyc % 2 == 0);
        2:       in_valid = (txq.size() > 0) && ($urandom_range(0, 3) != 0);
        default: in_valid = (txq.size() > 0);
      endcase
      in_data = (txq.size() > 0) ? txq[0] : 8'($urandom);
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) void'(txq.pop_front());
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("stim_timeout", 16'(timedOut), 16'd0);
  endtask

  task automatic loadFrame(input logic [63:0] v);
    for (int i = 7; i >= 0; i--) txq.push_back(v[i*8 +: 8]);
  endtask

  task automatic loadRandom();
    for (int i = 0; i < 8; i++) txq.push_back(8'($urandom));
  endtask

  initial begin
    int lats[4];
    bit sawLow;
    in_valid = 1'b0;
    in_data  = 8'd0;
    nrst     = 1'b1;
    #2;
    doReset();

    // Reference frame at full rate.
    loadFrame(64'h05_03_08_01_09_02_07_04);
    applyStimulus(0, 1'b0);
    checkOutput("t1_frame_cnt", frame_cnt, 16'd1);
    checkOutput("t1_sort_cycles", 16'(sort_cycles), 16'd45);

    // Duplicates and extremes, valid toggling every other cycle.
    loadFrame(64'h07_07_00_FF_00_07_FF_01);
    applyStimulus(1, 1'b0);

    // Downstream stall on the third byte.
    readyMode = 2;
    stallLeft = 10;
    loadRandom();
    applyStimulus(0, 1'b0);
    checkOutput("stall_used", 16'(stallLeft), 16'd0);
    readyMode = 0;

    // Reset while the engine is sorting, then a clean frame.
    loadRandom();
    applyStimulus(0, 1'b1);
    sawLow = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!eng_ready) begin
        sawLow = 1'b1;
        break;
      end
    end
    checkOutput("eng_went_busy", 16'(sawLow), 16'd1);
    repeat (10) @(posedge clk);
    #1;
    doReset();
    loadFrame(64'h05_03_08_01_09_02_07_04);
    applyStimulus(0, 1'b0);
    checkOutput("post_rst_frame_cnt", frame_cnt, 16'd1);

    // Two frames back to back; the second waits for the first to drain.
    doReset();
    readyMode = 1;
    loadRandom();
    loadRandom();
    applyStimulus(0, 1'b0);
    checkOutput("b2b_frame_cnt", frame_cnt, 16'd2);

    // Randomised frames with varying engine sort time.
    for (int f = 0; f < 6; f++) begin
      engLat = $urandom_range(1, 70);
      loadRandom();
      applyStimulus(f % 3, 1'b0);
    end

    // Busy-time counter around its saturation point and at its minimum.
    lats[0] = 255; lats[1] = 256; lats[2] = 300; lats[3] = 1;
    for (int i = 0; i < 4; i++) begin
      engLat = lats[i];
      loadRandom();
      applyStimulus(2, 1'b0);
    end
    checkOutput("final_frame_cnt", frame_cnt, 16'd12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed %0d miscompares expected completion", miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sort_stream_ctrl.md
# sort_stream_ctrl

Streaming front-end for the 8-entry, 8-bit selection-sort engine. Accepts frames of eight bytes on a valid/ready input stream, writes them into the engine, issues the start pulse, waits for completion, then reads the sorted bytes back out on a valid/ready output stream with a last marker. Sits between the byte-stream fabric and the sort engine, and is the engine's only master.

## Interface
Parameters
- FRAME_LEN, 8: bytes per frame. Fixed by the engine depth and not to be overridden.

Ports
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input byte valid
- in_ready  out  1  controller accepts input byte
- in_data  in  8  input byte
- out_valid  out  1  sorted byte valid
- out_ready  in  1  downstream accepts byte
- out_data  out  8  sorted byte
- out_last  out  1  high with 8th byte of frame
- eng_start  out  1  engine start pulse
- eng_wr  out  1  engine write strobe
- eng_addr  out  3  engine address
- eng_datain  out  8  engine write data
- eng_dataout  in  8  engine registered read data (1-cycle latency, updated when engine ready and eng_wr=0)
- eng_ready  in  1  engine idle
- busy  out  1  high in every state except LOAD
- sort_cycles  out  8  cycles eng_ready was low in last frame, saturating at 255
- frame_cnt  out  16  completed frames, wraps 0xFFFF->0

## Operation
- States: LOAD, KICK, WAIT_LO, WAIT_HI, READ, OUT. 3-bit index k.
- LOAD: in_ready=1. eng_wr=in_valid, eng_addr=k, eng_datain=in_data. On handshake, k++. Handshake at k=7 -> k=0, KICK.
- KICK: eng_start=1, eng_wr=0, one cycle -> WAIT_LO. Clears sort_cycles counter.
- WAIT_LO: eng_ready=0 -> WAIT_HI, count 1. Otherwise stay, no count.
- WAIT_HI: count each cycle eng_ready=0, saturate at 255. On eng_ready=1 -> READ.
- READ: eng_wr=0, eng_addr=k (ascending: k; see Configuration). Engine captures data this edge -> OUT.
- OUT: eng_addr held, out_valid=1, out_data=eng_dataout, out_last=(k==7). On out_ready: k==7 -> k=0, frame_cnt++, LOAD; else k++, READ.
- eng_start only in KICK. eng_wr only in LOAD with in_valid. All engine outputs combinational from state/k/inputs.
- Input bytes offered outside LOAD are not accepted (in_ready=0). No partial-frame flush.

## Timing
- Reset: state LOAD, k=0, in_ready=1, out_valid=0, out_last=0, eng_start=0, eng_wr=0 (in_valid low), busy=0, sort_cycles=0, frame_cnt=0.
- Load: 1 byte/cycle at full rate. KICK in the cycle after the 8th handshake.
- Engine sort time: eng_ready low for 45 cycles per frame, so sort_cycles=45.
- Drain: 2 cycles per byte minimum (READ+OUT). out_data stable while out_valid && !out_ready.
- Minimum frame period: 8 + 1 + 1 + 45 + 16 = 71 cycles.
- nrst mid-frame: controller returns to LOAD with k=0 immediately; engine memory content undefined to the protocol and overwritten by the next frame.
- out_ready held low indefinitely: stays in OUT, no timeout.

## Configuration
- SORT_DESCENDING_EN defined: READ drives eng_addr=7-k, so frame drains largest first. Undefined: eng_addr=k, smallest first. out_last always marks the 8th output byte.

## Test plan
- Reset then frame 5,3,8,1,9,2,7,4 at full rate, out_ready=1 -> output 1,2,3,4,5,7,8,9, out_last on 9, frame_cnt=1, sort_cycles=45.
- Same frame with SORT_DESCENDING_EN -> output 9,8,7,5,4,3,2,1, out_last on 1.
- Input with in_valid toggling every other cycle, duplicates 7,7,0,255,0,7,255,1 -> 0,0,1,7,7,7,255,255; eng_wr only on handshake cycles.
- out_ready low 10 cycles on 3rd output byte -> out_data/out_valid held constant, no byte lost or duplicated; in_ready=0 throughout drain.
- Assert nrst during WAIT_HI -> all outputs at reset values; next full frame sorts correctly, frame_cnt counts from 0.
- Two back-to-back frames, second offered during first drain -> second accepted only after first out_last handshake; frame_cnt=2.
